keypad_scanner: RTL

- Input-side counterpart to the seven-segment display scanner.
- The display scanner drives anodes outward one digit at a time. This block drives a 4x4 matrix keypad one column at a time and reads the rows back.
- It debounces the result and emits a single-cycle event carrying a 4-bit key code.
- It sits beside the display path in the top level and feeds key events to the math/display logic in place of raw switches.

---
 rtl/keypad_pkg.sv | 14 +
 rtl/keypad_tick_gen.sv | 30 +++
 rtl/keypad_scanner.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared types and sizes for the 4x4 matrix keypad scanner.
//   NUM_ROWS / NUM_COLS : matrix geometry
//   NUM_KEYS            : number of keys (key code = NUM_COLS*row + col)
//   state_t             : debounce FSM states
//   scan_res_t          : classification of one complete 16-key scan
package keypad_pkg;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
    typedef enum logic [1:0] {NONE, ONE, MULTI} scan_res_t;
endpackage

// File: rtl/keypad_tick_gen.sv
// keypad_tick_gen
//   Column dwell timer. Counts 0..SCAN_DIV-1 and raises col_tick on the last
//   count; col_tick is a clock enable, not a derived clock.
//   clock    in  board clock
//   reset    in  synchronous, active-low reset
//   col_tick out one-cycle enable at the end of each column dwell
module keypad_tick_gen #(
    parameter int SCAN_DIV = 100000
) (
    input  logic clock,
    input  logic reset,
    output logic col_tick
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign col_tick = (cnt == LAST);
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Drives a 4x4 keypad one column at a time (active-low), samples the rows
//   through a 2-flop synchronizer, classifies each full scan and debounces
//   the result into a single key event.
//   clock     in   board clock
//   reset     in   synchronous, active-low reset
//   row[3:0]  in   keypad rows, active-low
//   col[3:0]  out  keypad columns, active-low, one bit low at a time
//   key_code  out  accepted key, 4*row_idx + col_idx
//   key_valid out  one-cycle pulse per accepted press
//   key_held  out  high while the accepted key remains down
//   Build option: define KEYPAD_REPEAT_EN to re-pulse key_valid every
//   REPEAT_SCANS scans while a key stays in PRESSED.
//
//   state    | meaning
//   IDLE     | no key accepted, waiting for a single-key scan
//   DEBOUNCE | counting consecutive scans showing the same single key
//   PRESSED  | key accepted, key_held high
//   RELEASE  | counting consecutive empty scans before dropping key_held
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
`ifdef KEYPAD_REPEAT_EN
    parameter int REPEAT_SCANS   = 50,
`endif
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic                key_held
);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_SCANS);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_SCANS - 1);

    logic                                 col_tick;
    logic [1:0]                           col_idx;
    logic [NUM_ROWS-1:0]                  row_s1;
    logic [NUM_ROWS-1:0]                  row_s2;
    logic [NUM_COLS-1:0][NUM_ROWS-1:0]    snap;
    logic                                 scan_done;
    logic                                 any_low;
    logic                                 multi_low;
    logic [3:0]                           scan_code;
    scan_res_t                            scan_res;
    state_t                               state;
    logic [3:0]                           cand;
    logic [DW-1:0]                        match_cnt;
    logic [DW-1:0]                        rel_cnt;
`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_SCANS + 1);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_SCANS - 1);
    logic [RW-1:0]                        rpt_cnt;
`endif

    keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clock    (clock),
        .reset    (reset),
        .col_tick (col_tick)
    );

    // Snapshot of a column is taken at the end of its dwell, before col moves,
    // so the rows have had the whole dwell (minus sync delay) to settle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            col_idx   <= '0;
            col       <= 4'b1110;
            row_s1    <= '1;
            row_s2    <= '1;
            snap      <= '1;
            scan_done <= 1'b0;
        end else begin
            row_s1    <= row;
            row_s2    <= row_s1;
            scan_done <= col_tick && (col_idx == 2'd3);
            if (col_tick) begin
                snap[col_idx] <= row_s2;
                col_idx       <= col_idx + 2'd1;
                col           <= {col[2:0], col[3]};
            end
        end
    end

    always_comb begin
        any_low   = 1'b0;
        multi_low = 1'b0;
        scan_code = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (!snap[c][r]) begin
                    if (any_low) multi_low = 1'b1;
                    else         scan_code = 4'(NUM_COLS * r + c);
                    any_low = 1'b1;
                end
            end
        end
        if (multi_low)    scan_res = MULTI;
        else if (any_low) scan_res = ONE;
        else              scan_res = NONE;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            cand      <= '0;
            match_cnt <= '0;
            rel_cnt   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt   <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (scan_done) begin
                case (state)
                    IDLE: begin
                        if (scan_res == ONE) begin
                            cand      <= scan_code;
                            match_cnt <= DW'(1);
                            // A single required scan accepts straight from IDLE.
                            if (DEBOUNCE_SCANS == 1) begin
                                key_code  <= scan_code;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                rel_cnt   <= '0;
                                state     <= PRESSED;
                            end else begin
                                state <= DEBOUNCE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (scan_res == ONE && scan_code == cand) begin
                            if (match_cnt != DEB_MAX) match_cnt <= match_cnt + 1'b1;
                            if (match_cnt == DEB_LAST) begin
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                rel_cnt   <= '0;
                                state     <= PRESSED;
                            end
                        end else if (scan_res == ONE) begin
                            cand      <= scan_code;
                            match_cnt <= DW'(1);
                        end else begin
                            match_cnt <= '0;
                            state     <= IDLE;
                        end
                    end
                    PRESSED: begin
                        if (scan_res == NONE) begin
                            rel_cnt <= DW'(1);
`ifdef KEYPAD_REPEAT_EN
                            rpt_cnt <= '0;
`endif
                            if (DEBOUNCE_SCANS == 1) begin
                                key_held <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                state <= RELEASE;
                            end
                        end else begin
                            // Any key-down result keeps the accepted key held.
                            rel_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
                            if (rpt_cnt >= RPT_LAST) begin
                                key_valid <= 1'b1;
                                rpt_cnt   <= '0;
                            end else begin
                                rpt_cnt <= rpt_cnt + 1'b1;
                            end
`endif
                        end
                    end
                    RELEASE: begin
                        if (scan_res == NONE) begin
                            if (rel_cnt != DEB_MAX) rel_cnt <= rel_cnt + 1'b1;
                            if (rel_cnt >= DEB_LAST) begin
                                key_held <= 1'b0;
                                state    <= IDLE;
                            end
                        end else begin
                            rel_cnt <= '0;
                            state   <= PRESSED;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
